// File: rtl/mem_pkg.sv
// Shared types and constants for the pipeline memory stage: FSM states,
// address/write-source select encodings, stack frame lengths.
package mem_pkg;

   localparam int DATA_W         = 16;
   localparam int PC_W           = 32;
   localparam int DEFAULT_ADDR_W = 12;

   // Sequencer states; the state value doubles as the frame word index.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      W1   = 2'd1,
      W2   = 2'd2
   } state_t;

   // memory_address_select encodings (10/11 behave as ADDR_ALU).
   typedef enum logic [1:0] {
      ADDR_ALU  = 2'b00,
      ADDR_RSRC = 2'b01
   } addr_sel_t;

   // memory_write_src_select encodings (11 behaves as SRC_RDEST).
   typedef enum logic [1:0] {
      SRC_RDEST = 2'b00,
      SRC_PC    = 2'b01,
      SRC_INT   = 2'b10
   } wsrc_sel_t;

   // Number of memory words moved by one stack operation.
   localparam logic [1:0] FRAME_WORD = 2'd1;
   localparam logic [1:0] FRAME_CALL = 2'd2;
   localparam logic [1:0] FRAME_INT  = 2'd3;

   // Frame length of the operation currently presented by the execute stage.
   function automatic logic [1:0] frame_length(input logic push,
                                               input logic pop,
                                               input logic [1:0] src_sel,
                                               input logic choose_mem,
                                               input logic choose_int);
      if (push) begin
         if (src_sel == SRC_PC)  return FRAME_CALL;
         if (src_sel == SRC_INT) return FRAME_INT;
         return FRAME_WORD;
      end
      if (pop) begin
         if (choose_int) return FRAME_INT;
         if (choose_mem) return FRAME_CALL;
      end
      return FRAME_WORD;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM buffer signals consumed by the memory stage, plus the stall
// returned upstream. The execute side is the master.
interface mem_stage_if;
   logic [15:0] alu_result;
   logic [15:0] read_data1;
   logic [15:0] read_data2;
   logic [31:0] pc_plus_one;
   logic [2:0]  flags_in;
   logic [15:0] LDM_value;
   logic        mem_read;
   logic        mem_write;
   logic        mem_push;
   logic        mem_pop;
   logic [1:0]  memory_address_select;
   logic [1:0]  memory_write_src_select;
   logic        pc_choose_memory;
   logic        pc_choose_interrupt;
   logic        reg_write;
   logic [2:0]  reg_write_address;
   logic [1:0]  wb_sel;
   logic        stall;

   modport master (
      output alu_result, read_data1, read_data2, pc_plus_one, flags_in, LDM_value,
             mem_read, mem_write, mem_push, mem_pop, memory_address_select,
             memory_write_src_select, pc_choose_memory, pc_choose_interrupt,
             reg_write, reg_write_address, wb_sel,
      input  stall
   );

   modport slave (
      input  alu_result, read_data1, read_data2, pc_plus_one, flags_in, LDM_value,
             mem_read, mem_write, mem_push, mem_pop, memory_address_select,
             memory_write_src_select, pc_choose_memory, pc_choose_interrupt,
             reg_write, reg_write_address, wb_sel,
      output stall
   );
endinterface

// File: rtl/data_memory.sv
// Single-port data memory: synchronous write, combinational read.
module data_memory #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [15:0]       wdata,
   output logic [15:0]       rdata
);

   logic [15:0] mem [2**ADDR_W];

   // Write port.
   // NOTE: storage has no reset so it maps onto RAM; contents survive stage reset.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: loads/stores, stack push/pop with multi-word
// CALL/RET and interrupt/RTI frames, stack pointer and MEM/WB buffer.
module mem_stage
   import mem_pkg::*;
#(
   parameter int                ADDR_W   = DEFAULT_ADDR_W,
   parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
   input  logic              clk,
   input  logic              reset,
   mem_stage_if.slave        ex,
   output logic [15:0]       mem_data_out,
   output logic [15:0]       alu_result_out,
   output logic [15:0]       LDM_value_out,
   output logic              reg_write_out,
   output logic [2:0]        reg_write_address_out,
   output logic [1:0]        wb_sel_out,
   output logic [31:0]       pc_from_memory,
   output logic              pc_load,
   output logic [2:0]        flags_from_memory,
   output logic              flags_load,
   output logic [ADDR_W-1:0] sp_out
);

   state_t            state, state_n;
   logic [ADDR_W-1:0] sp, sp_n, addr;
   logic [1:0]        frame_len, word_idx;
   logic              is_push, is_pop, is_ret, is_rti, last_word, we, load_en;
   logic              pc_lo_cap, pc_done, flags_done;
   logic [15:0]       wdata, rd_data, pc_lo;
   logic              unused_bits;

   assign unused_bits = ^ex.read_data2[15:ADDR_W];

   data_memory #(.ADDR_W(ADDR_W)) u_data_memory (
      .clk   (clk),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rd_data)
   );

   // Decode the access, sequence frame words and derive memory/SP controls.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_n    = IDLE;
      sp_n       = sp;
      addr       = ex.alu_result[ADDR_W-1:0];
      wdata      = ex.read_data1;
      word_idx   = state;
      is_push    = ex.mem_push;
      is_pop     = ex.mem_pop & ~ex.mem_push;
      is_rti     = is_pop & ex.pc_choose_interrupt;
      is_ret     = is_pop & ~ex.pc_choose_interrupt & ex.pc_choose_memory;
      frame_len  = frame_length(is_push, is_pop, ex.memory_write_src_select,
                                ex.pc_choose_memory, ex.pc_choose_interrupt);

      case (state)
         IDLE:    if (frame_len != FRAME_WORD) state_n = W1;
         W1:      if (frame_len == FRAME_INT)  state_n = W2;
         default: state_n = IDLE;
      endcase
      last_word = (state_n == IDLE);

      if (is_push) begin
         addr = sp;
         sp_n = sp - 1'b1;
         case (ex.memory_write_src_select)
            SRC_PC:  wdata = (word_idx == 2'd0) ? ex.pc_plus_one[31:16] : ex.pc_plus_one[15:0];
            SRC_INT: begin
               if (word_idx == 2'd0)      wdata = ex.pc_plus_one[31:16];
               else if (word_idx == 2'd1) wdata = ex.pc_plus_one[15:0];
               else                       wdata = {13'b0, ex.flags_in};
            end
            default: wdata = ex.read_data1;
         endcase
      end else if (is_pop) begin
         addr = sp + 1'b1;
         sp_n = sp + 1'b1;
      end else if (ex.memory_address_select == ADDR_RSRC) begin
         addr = ex.read_data2[ADDR_W-1:0];
      end

      we         = ~reset & (is_push | (~is_pop & ex.mem_write));
      load_en    = is_pop | (~is_push & ex.mem_read);
      pc_lo_cap  = (is_ret & word_idx == 2'd0) | (is_rti & word_idx == 2'd1);
      pc_done    = (is_ret & word_idx == 2'd1) | (is_rti & word_idx == 2'd2);
      flags_done = is_rti & (word_idx == 2'd0);
   end

   // Upstream holds its inputs on every frame word except the last.
   assign ex.stall = ~reset & ~last_word;
   assign sp_out   = sp;

   // Sequencer state and stack pointer.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state <= IDLE;
         sp    <= SP_RESET;
      end else begin
         state <= state_n;
         sp    <= sp_n;
      end
   end

   // MEM/WB buffer, popped PC/flags and their load pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_data_out          <= '0;
         alu_result_out        <= '0;
         LDM_value_out         <= '0;
         reg_write_out         <= 1'b0;
         reg_write_address_out <= '0;
         wb_sel_out            <= '0;
         pc_from_memory        <= '0;
         pc_load               <= 1'b0;
         flags_from_memory     <= '0;
         flags_load            <= 1'b0;
         pc_lo                 <= '0;
      end else begin
         if (load_en) mem_data_out <= rd_data;
         alu_result_out        <= ex.alu_result;
         LDM_value_out         <= ex.LDM_value;
         reg_write_out         <= ex.reg_write & last_word;
         reg_write_address_out <= ex.reg_write_address;
         wb_sel_out            <= ex.wb_sel;
         pc_load               <= pc_done;
         flags_load            <= flags_done;
         if (pc_lo_cap)  pc_lo             <= rd_data;
         if (pc_done)    pc_from_memory    <= {rd_data, pc_lo};
         if (flags_done) flags_from_memory <= rd_data[2:0];
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] mem_data_out, alu_result_out, LDM_value_out;
   logic        reg_write_out, pc_load, flags_load;
   logic [2:0]  reg_write_address_out, flags_from_memory;
   logic [1:0]  wb_sel_out;
   logic [31:0] pc_from_memory;
   logic [11:0] sp_out;
   int          tests = 0;
   int          fails = 0;

   mem_stage_if bus ();

   mem_stage #(.ADDR_W(12), .SP_RESET(12'hFFF)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .ex                    (bus),
      .mem_data_out          (mem_data_out),
      .alu_result_out        (alu_result_out),
      .LDM_value_out         (LDM_value_out),
      .reg_write_out         (reg_write_out),
      .reg_write_address_out (reg_write_address_out),
      .wb_sel_out            (wb_sel_out),
      .pc_from_memory        (pc_from_memory),
      .pc_load               (pc_load),
      .flags_from_memory     (flags_from_memory),
      .flags_load            (flags_load),
      .sp_out                (sp_out)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu_result = '0; bus.read_data1 = '0; bus.read_data2 = '0;
      bus.pc_plus_one = '0; bus.flags_in = '0; bus.LDM_value = '0;
      bus.mem_read = 0; bus.mem_write = 0; bus.mem_push = 0; bus.mem_pop = 0;
      bus.memory_address_select = 2'b00; bus.memory_write_src_select = 2'b00;
      bus.pc_choose_memory = 0; bus.pc_choose_interrupt = 0;
      bus.reg_write = 0; bus.reg_write_address = '0; bus.wb_sel = '0;
   endtask

   task automatic test_reset();
      tick(); tick();
      tests++; if (sp_out !== 12'hFFF) begin fails++; $display("FAIL reset_sp: got %h expected fff", sp_out); end
      tests++; if (mem_data_out !== 16'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", mem_data_out); end
      tests++; if ({pc_load, flags_load, reg_write_out} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b expected 000", {pc_load, flags_load, reg_write_out}); end
      tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
      reset = 0;
   endtask

   task automatic test_load_store();
      bus.mem_write = 1; bus.alu_result = 16'h0010; bus.read_data1 = 16'hBEEF;
      #1;
      tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL store_stall: got %b expected 0", bus.stall); end
      tick();
      idle_inputs();
      bus.mem_read = 1; bus.alu_result = 16'h0010; bus.reg_write = 1;
      bus.reg_write_address = 3'd5; bus.wb_sel = 2'b01; bus.LDM_value = 16'h1234;
      #1;
      tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL load_stall: got %b expected 0", bus.stall); end
      tick();
      tests++; if (mem_data_out !== 16'hBEEF) begin fails++; $display("FAIL load_data: got %h expected beef", mem_data_out); end
      tests++; if ({reg_write_out, reg_write_address_out, wb_sel_out} !== 6'b1_101_01) begin fails++; $display("FAIL load_ctrl: got %b expected 110101", {reg_write_out, reg_write_address_out, wb_sel_out}); end
      tests++; if ({alu_result_out, LDM_value_out} !== 32'h0010_1234) begin fails++; $display("FAIL load_pass: got %h expected 00101234", {alu_result_out, LDM_value_out}); end
      // Address taken from read_data2, then write+read of the same word.
      idle_inputs();
      bus.mem_read = 1; bus.memory_address_select = 2'b01; bus.read_data2 = 16'h0010;
      tick();
      tests++; if (mem_data_out !== 16'hBEEF) begin fails++; $display("FAIL load_rsrc: got %h expected beef", mem_data_out); end
      idle_inputs();
      bus.mem_read = 1; bus.mem_write = 1; bus.alu_result = 16'h0010; bus.read_data1 = 16'hCAFE;
      tick();
      tests++; if (mem_data_out !== 16'hBEEF) begin fails++; $display("FAIL rw_prewrite: got %h expected beef", mem_data_out); end
      idle_inputs();
      bus.mem_read = 1; bus.alu_result = 16'h0010;
      tick();
      tests++; if (mem_data_out !== 16'hCAFE) begin fails++; $display("FAIL rw_postwrite: got %h expected cafe", mem_data_out); end
      idle_inputs();
   endtask

   task automatic test_push_pop();
      bus.mem_push = 1; bus.read_data1 = 16'h1111;
      tick();
      tests++; if (sp_out !== 12'hFFE) begin fails++; $display("FAIL push1_sp: got %h expected ffe", sp_out); end
      bus.read_data1 = 16'h2222;
      #1;
      tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL push_stall: got %b expected 0", bus.stall); end
      tick();
      tests++; if (sp_out !== 12'hFFD) begin fails++; $display("FAIL push2_sp: got %h expected ffd", sp_out); end
      idle_inputs();
      bus.mem_pop = 1;
      tick();
      tests++; if ({sp_out, mem_data_out} !== {12'hFFE, 16'h2222}) begin fails++; $display("FAIL pop1: got %h/%h expected ffe/2222", sp_out, mem_data_out); end
      tick();
      tests++; if ({sp_out, mem_data_out} !== {12'hFFF, 16'h1111}) begin fails++; $display("FAIL pop2: got %h/%h expected fff/1111", sp_out, mem_data_out); end
      idle_inputs();
   endtask

   task automatic test_call_ret();
      bus.mem_push = 1; bus.memory_write_src_select = 2'b01;
      bus.pc_plus_one = 32'h0001_0020; bus.reg_write = 1;
      #1;
      tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL call_stall0: got %b expected 1", bus.stall); end
      tick();
      tests++; if ({bus.stall, reg_write_out, sp_out} !== {2'b00, 12'hFFE}) begin fails++; $display("FAIL call_w1: got %b %b %h expected 0 0 ffe", bus.stall, reg_write_out, sp_out); end
      tick();
      tests++; if ({reg_write_out, sp_out} !== {1'b1, 12'hFFD}) begin fails++; $display("FAIL call_end: got %b %h expected 1 ffd", reg_write_out, sp_out); end
      idle_inputs();
      bus.mem_pop = 1; bus.pc_choose_memory = 1;
      #1;
      tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL ret_stall0: got %b expected 1", bus.stall); end
      tick();
      tests++; if ({pc_load, sp_out, mem_data_out} !== {1'b0, 12'hFFE, 16'h0020}) begin fails++; $display("FAIL ret_w0: got %b %h %h expected 0 ffe 0020", pc_load, sp_out, mem_data_out); end
      tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL ret_stall1: got %b expected 0", bus.stall); end
      tick();
      tests++; if ({pc_load, pc_from_memory, sp_out, mem_data_out} !== {1'b1, 32'h0001_0020, 12'hFFF, 16'h0001}) begin fails++; $display("FAIL ret_pc: got %b %h %h %h expected 1 00010020 fff 0001", pc_load, pc_from_memory, sp_out, mem_data_out); end
      idle_inputs();
      tick();
      tests++; if (pc_load !== 1'b0) begin fails++; $display("FAIL ret_pulse: got %b expected 0", pc_load); end
   endtask

   task automatic test_int_rti();
      bus.mem_push = 1; bus.memory_write_src_select = 2'b10;
      bus.pc_plus_one = 32'hABCD_1234; bus.flags_in = 3'b101;
      #1;
      tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL int_stall0: got %b expected 1", bus.stall); end
      tick();
      tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL int_stall1: got %b expected 1", bus.stall); end
      tick();
      tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL int_stall2: got %b expected 0", bus.stall); end
      tick();
      tests++; if (sp_out !== 12'hFFC) begin fails++; $display("FAIL int_sp: got %h expected ffc", sp_out); end
      idle_inputs();
      bus.mem_pop = 1; bus.pc_choose_interrupt = 1;
      #1;
      tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL rti_stall0: got %b expected 1", bus.stall); end
      tick();
      tests++; if ({flags_load, flags_from_memory, mem_data_out} !== {1'b1, 3'b101, 16'h0005}) begin fails++; $display("FAIL rti_flags: got %b %b %h expected 1 101 0005", flags_load, flags_from_memory, mem_data_out); end
      tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL rti_stall1: got %b expected 1", bus.stall); end
      tick();
      tests++; if ({flags_load, pc_load, mem_data_out} !== {2'b00, 16'h1234}) begin fails++; $display("FAIL rti_w1: got %b %b %h expected 0 0 1234", flags_load, pc_load, mem_data_out); end
      tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL rti_stall2: got %b expected 0", bus.stall); end
      tick();
      tests++; if ({pc_load, pc_from_memory, sp_out} !== {1'b1, 32'hABCD_1234, 12'hFFF}) begin fails++; $display("FAIL rti_pc: got %b %h %h expected 1 abcd1234 fff", pc_load, pc_from_memory, sp_out); end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid_frame();
      bus.mem_push = 1; bus.memory_write_src_select = 2'b10;
      bus.pc_plus_one = 32'h5555_6666; bus.flags_in = 3'b011; bus.alu_result = 16'h00AA;
      tick();
      reset = 1;
      #1;
      tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL rst_mid_stall: got %b expected 0", bus.stall); end
      tick();
      idle_inputs();
      reset = 0;
      #1;
      tests++; if ({bus.stall, sp_out} !== {1'b0, 12'hFFF}) begin fails++; $display("FAIL rst_mid_state: got %b %h expected 0 fff", bus.stall, sp_out); end
      tests++; if ({mem_data_out, alu_result_out, pc_from_memory, flags_from_memory} !== 67'h0) begin fails++; $display("FAIL rst_mid_outs: got %h %h %h %b expected zeros", mem_data_out, alu_result_out, pc_from_memory, flags_from_memory); end
      bus.mem_read = 1; bus.alu_result = 16'h0FFF;
      tick();
      tests++; if (mem_data_out !== 16'h5555) begin fails++; $display("FAIL rst_mid_mem: got %h expected 5555", mem_data_out); end
      idle_inputs();
   endtask

   task automatic test_wrap();
      bus.mem_pop = 1;
      tick();
      tests++; if (sp_out !== 12'h000) begin fails++; $display("FAIL wrap_pop_sp: got %h expected 000", sp_out); end
      idle_inputs();
      bus.mem_push = 1; bus.read_data1 = 16'h7777;
      tick();
      tests++; if (sp_out !== 12'hFFF) begin fails++; $display("FAIL wrap_push_sp: got %h expected fff", sp_out); end
      idle_inputs();
      bus.mem_read = 1; bus.alu_result = 16'h0000;
      tick();
      tests++; if (mem_data_out !== 16'h7777) begin fails++; $display("FAIL wrap_mem: got %h expected 7777", mem_data_out); end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_load_store();
      test_push_pop();
      test_call_ret();
      test_int_rti();
      test_reset_mid_frame();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
